// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
// Writes an LFSR pattern to words 0..num_words-1 of an SDRAM through an
// Avalon-MM master, reads the words back with up to MAX_PEND pipelined reads
// in flight, and counts mismatching words.
//
// Handshake: a command (avm_write or avm_read) is a valid; avm_waitrequest
// low is the ready. A command transfers on a cycle where its strobe is high
// and avm_waitrequest is low. While a strobe is high and waitrequest is high,
// the strobe, address and write data stay unchanged. avm_readdatavalid has no
// back-pressure: every pulse delivers one read word, in issue order.
module sdram_pattern_tester #(
  parameter int ADDR_W   = 24,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [15:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [2:0]        state_dbg
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] MAX_PEND_C = PEND_W'(MAX_PEND);
  localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   words_q;
  logic [15:0]         seed_q;
  logic [15:0]         chk_lfsr;
  logic [ADDR_W-1:0]   rd_idx;
  logic [PEND_W-1:0]   pend;

  logic [ADDR_W-1:0]   last_addr;
  logic [15:0]         seed_eff;
  logic                wr_acc;
  logic                rd_acc;
  logic                rv_take;
  logic                mismatch;
  logic [PEND_W-1:0]   pend_next;

  // One Galois step, taps x^16+x^14+x^13+x^11+1 (right-shifting form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] sh;
    sh = {1'b0, s[15:1]};
    lfsr_step = s[0] ? (sh ^ 16'hB400) : sh;
  endfunction

  assign avm_byteenable = 2'b11;
  assign state_dbg      = state;
  assign last_addr      = words_q - 1'b1;
  assign seed_eff       = (seed == 16'h0000) ? ZERO_SEED_SUB : seed;

  // Transfer qualifiers and next outstanding-read count.
  always_comb begin
    wr_acc    = avm_write & ~avm_waitrequest;
    rd_acc    = avm_read & ~avm_waitrequest;
    // Returned words only count while reading and only against a real
    // outstanding read; anything else is a stray from before a reset.
    rv_take   = avm_readdatavalid &&
                ((state == S_READ) || (state == S_DRAIN)) &&
                (pend != '0);
    mismatch  = rv_take && (avm_readdata != chk_lfsr);
    pend_next = pend;
    if (rd_acc) begin
      pend_next = pend_next + PEND_W'(1);
    end
    if (rv_take) begin
      pend_next = pend_next - PEND_W'(1);
    end
  end

  // Control FSM, command generation, and read-back checker.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 16'h0000;
      first_err_addr <= '0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= 16'h0000;
      words_q        <= '0;
      seed_q         <= 16'h0000;
      chk_lfsr       <= 16'h0000;
      rd_idx         <= '0;
      pend           <= '0;
    end else begin
      done <= 1'b0;
      pend <= pend_next;

      // Checker: one LFSR step and one index step per returned word.
      if (rv_take) begin
        chk_lfsr <= lfsr_step(chk_lfsr);
        rd_idx   <= rd_idx + 1'b1;
        if (mismatch) begin
          if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h0001;
          end
          if (err_count == 16'h0000) begin
            first_err_addr <= rd_idx;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            words_q        <= num_words;
            seed_q         <= seed_eff;
            err_count      <= 16'h0000;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            if (num_words == '0) begin
              state <= S_FINISH;
            end else begin
              state         <= S_WRITE;
              avm_write     <= 1'b1;
              avm_address   <= '0;
              avm_writedata <= seed_eff;
            end
          end
        end

        S_WRITE: begin
          if (wr_acc) begin
            if (avm_address == last_addr) begin
              // Last write taken: the first read goes out on the next cycle.
              state       <= S_READ;
              avm_write   <= 1'b0;
              avm_address <= '0;
              avm_read    <= 1'b1;
              chk_lfsr    <= seed_q;
              rd_idx      <= '0;
            end else begin
              avm_address   <= avm_address + 1'b1;
              avm_writedata <= lfsr_step(avm_writedata);
            end
          end
        end

        S_READ: begin
          // A stalled read holds everything; otherwise decide the next cycle.
          if (!(avm_read && avm_waitrequest)) begin
            if (rd_acc && (avm_address == last_addr)) begin
              avm_read <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              if (rd_acc) begin
                avm_address <= avm_address + 1'b1;
              end
              // Issue only if the read would not exceed the in-flight limit.
              avm_read <= (pend_next < MAX_PEND_C);
            end
          end
        end

        S_DRAIN: begin
          if (pend == '0) begin
            state <= S_FINISH;
          end
        end

        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == 16'h0000);
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
